// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-aligned value updates.
// Optional leading-zero suppression is compiled in with `define SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  output logic [3:0]              hex,
  output logic                    dp,
  output logic                    enable,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_DIGITS-1:0][3:0] disp_val, disp_val_n, pend_val;
  logic [NUM_DIGITS-1:0]      disp_dp, disp_dp_n, pend_dp;
  logic pend_valid, slot_end, frame_end, sup_n, show_n;

  // Outputs are registered from next-state values so they line up with cnt/idx/display.
  always_comb begin
    slot_end   = (cnt == LAST_CNT);
    frame_end  = slot_end && (idx == LAST_IDX);
    cnt_n      = slot_end ? '0 : cnt + 1'b1;
    idx_n      = idx;
    disp_val_n = disp_val;
    disp_dp_n  = disp_dp;
    if (slot_end) idx_n = frame_end ? '0 : idx + 1'b1;
    if (frame_end) begin
      if (load) begin
        disp_val_n = value;
        disp_dp_n  = dp_mask;
      end else if (pend_valid) begin
        disp_val_n = pend_val;
        disp_dp_n  = pend_dp;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  // lz[i]: digit i and everything above it is zero with no DP lit.
  logic [NUM_DIGITS-1:0] lz;
  assign lz[0] = 1'b0;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
    assign lz[i] = ~|{disp_val_n[NUM_DIGITS-1:i], disp_dp_n[NUM_DIGITS-1:i]};
  end
  assign sup_n = lz[idx_n];
`else
  assign sup_n = 1'b0;
`endif

  assign show_n = (cnt_n >= BLANK_END) && !sup_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      hex        <= 4'h0;
      dp         <= 1'b1;
      enable     <= 1'b0;
      an         <= '1;
      scan_done  <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      idx      <= idx_n;
      disp_val <= disp_val_n;
      disp_dp  <= disp_dp_n;
      // A load coinciding with the boundary went straight to the display.
      if (frame_end) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_mask;
        pend_valid <= 1'b1;
      end
      hex       <= disp_val_n[idx_n];
      dp        <= ~disp_dp_n[idx_n];
      enable    <= show_n;
      an        <= show_n ? ~(NUM_DIGITS'(1) << idx_n) : '1;
      scan_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif
  localparam logic [3:0] LZ0 = LZ_ON ? 4'b0001 : 4'b1111;

  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_mask = '0;
  logic [3:0] hex, an;
  logic dp, enable, scan_done;
  int total = 0, bad = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .load(load),
    .hex(hex), .dp(dp), .enable(enable), .an(an), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpm;
    logic [3:0]  lz_show;  // slots expected lit when suppression is built in
  } vec_t;
  vec_t tbl [6];

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Cycle k of a frame: slot k/8, cnt k%8; BLANK for cnt<2.
  task automatic check_cycle(input logic [15:0] v, input logic [3:0] m, input logic [3:0] show,
                             input int k, input logic sd, input string nm);
    int s, c;
    logic en;
    logic [3:0] an_e, one;
    logic [10:0] e, a;
    s = k / 8;
    c = k % 8;
    one = 4'b0001;
    en = (c >= 2) && show[s];
    an_e = en ? ~(one << s) : 4'hF;
    e = {v[4*s +: 4], ~m[s], en, an_e, sd};
    a = {hex, dp, enable, an, scan_done};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s k=%0d got{hex,dp,en,an,sd}=%h want=%h", nm, k, a, e);
    end
  endtask

  task automatic check_frame(input logic [15:0] v, input logic [3:0] m, input logic [3:0] show,
                             input logic sd0, input string nm);
    for (int k = 0; k < 32; k++) begin
      check_cycle(v, m, show, k, (k == 0) ? sd0 : 1'b0, nm);
      step();
    end
  endtask

  task automatic wait_sd();
    bit found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (scan_done) found = 1;
      else step();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_sd timeout got=0 want=1");
    end
  endtask

  task automatic check_bit(input logic a, input logic e, input string nm);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  initial begin
    tbl[0] = '{16'h1A3F, 4'b0100, 4'b1111};
    tbl[1] = '{16'h0042, 4'b0000, 4'b0011};
    tbl[2] = '{16'h0000, 4'b0000, 4'b0001};
    tbl[3] = '{16'h0000, 4'b1000, 4'b1111};
    tbl[4] = '{16'hFFFF, 4'b1111, 4'b1111};
    tbl[5] = '{16'h8421, 4'b1001, 4'b1111};

    // reset held for 3 cycles, then first frame from cnt=0
    for (int i = 0; i < 3; i++) begin
      step();
      check_cycle(16'h0, 4'h0, LZ0, 0, 1'b0, "reset");
    end
    rst = 1'b0;
    check_frame(16'h0, 4'h0, LZ0, 1'b0, "post_reset");

    // table: load mid-frame, expect it on the next frame
    for (int t = 0; t < 6; t++) begin
      wait_sd();
      load = 1'b1; value = tbl[t].val; dp_mask = tbl[t].dpm;
      step();
      load = 1'b0;
      wait_sd();
      check_frame(tbl[t].val, tbl[t].dpm, LZ_ON ? tbl[t].lz_show : 4'hF, 1'b1, "table");
    end

    // tear-free: two loads in slot 1, old digits held to frame end
    for (int k = 0; k < 32; k++) begin
      check_cycle(16'h8421, 4'b1001, 4'hF, k, k == 0, "tear_old");
      if (k == 9)  begin load = 1'b1; value = 16'h0000; dp_mask = 4'h0; end
      if (k == 10) begin load = 1'b1; value = 16'h5555; end
      if (k == 11) load = 1'b0;
      step();
    end
    check_frame(16'h5555, 4'h0, 4'hF, 1'b1, "tear_new");

    // boundary bypass: pending 3333 overridden by 7777 strobed on the boundary
    for (int k = 0; k < 32; k++) begin
      check_cycle(16'h5555, 4'h0, 4'hF, k, k == 0, "bypass_old");
      if (k == 4)  begin load = 1'b1; value = 16'h3333; dp_mask = 4'h0; end
      if (k == 5)  load = 1'b0;
      if (k == 31) begin load = 1'b1; value = 16'h7777; dp_mask = 4'b0010; end
      step();
    end
    load = 1'b0;
    check_bit(dut.pend_valid, 1'b0, "bypass_pend_valid");
    check_frame(16'h7777, 4'b0010, 4'hF, 1'b1, "bypass_f0");
    check_frame(16'h7777, 4'b0010, 4'hF, 1'b1, "bypass_f1");

    // mid-frame reset at slot 2, cnt 5
    for (int k = 0; k < 21; k++) begin
      check_cycle(16'h7777, 4'b0010, 4'hF, k, k == 0, "pre_rst");
      step();
    end
    rst = 1'b1;
    step();
    check_cycle(16'h0, 4'h0, LZ0, 0, 1'b0, "midrst");
    check_bit(dut.disp_val == '0, 1'b1, "midrst_disp_zero");
    rst = 1'b0;
    check_frame(16'h0, 4'h0, LZ0, 1'b0, "after_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
